sr_reg_bank: RTL and testbench
==============================

SR_REG_BANK -- requirements
Module: sr_reg_bank

Interface
REQ-001 Parameter WIDTH, default 4, number of independent SR channels (1..32).
REQ-002 Parameter MODE, default SR_HOLD, behaviour of a channel when s=1 and r=1 (type sr_mode_t).
REQ-003 Parameter RST_VAL, default '0, WIDTH-bit reset value of q.
REQ-004 Parameter CNT_W, default 8, width of conflict_cnt.
REQ-005 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 en  input  1  update enable; 0 freezes every channel.
REQ-008 s  input  WIDTH  per-channel set request.
REQ-009 r  input  WIDTH  per-channel reset request.
REQ-010 err_clr  input  1  clears err_sticky and conflict_cnt.
REQ-011 q  output  WIDTH  registered channel state.
REQ-012 qbar  output  WIDTH  bitwise inverse of q.
REQ-013 conflict  output  WIDTH  registered one-cycle pulse per channel that saw s=r=1 while en=1.
REQ-014 err_sticky  output  WIDTH  per-channel sticky conflict flag.
REQ-015 conflict_cnt  output  CNT_W  saturating count of conflict cycles (present only when SR_REG_BANK_CNT_EN is defined).

Function
REQ-016 On each rising clk with en=1, each channel i SHALL update: s=1,r=0 -> q=1; s=0,r=1 -> q=0; s=0,r=0 -> hold.
REQ-017 For s=1,r=1 with en=1, channel SHALL follow MODE: SR_HOLD -> hold; SR_SET_DOM -> 1; SR_RST_DOM -> 0; SR_TOGGLE -> ~q.
REQ-018 With en=0, q SHALL hold and conflict SHALL be 0 on the next edge regardless of s/r.
REQ-019 qbar SHALL equal ~q at all times, including during reset, with zero cycle latency from q.
REQ-020 Latency s/r -> q SHALL be exactly one clock edge; s/r -> conflict exactly one edge.
REQ-021 conflict[i] SHALL be 1 for exactly the cycle following each edge where en=1 and s[i]=r[i]=1, and 0 otherwise.
REQ-022 err_sticky[i] SHALL set on the same edge conflict[i] is set and stay 1 until an edge with err_clr=1.
REQ-023 Simultaneous err_clr=1 and a new conflict on channel i SHALL leave err_sticky[i]=1 (set wins).
REQ-024 conflict_cnt SHALL increment by 1 on every edge where any channel records a conflict, independent of how many channels conflict.
REQ-025 conflict_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 err_clr=1 with a simultaneous conflict SHALL load conflict_cnt to 1; err_clr=1 alone loads 0.
REQ-027 err_clr SHALL act regardless of en.

Reset
REQ-028 Assertion of reset=0 SHALL immediately, without a clock, force q=RST_VAL, qbar=~RST_VAL, conflict=0, err_sticky=0, conflict_cnt=0.
REQ-029 Reset mid-operation SHALL discard any pending update; first update occurs on the first rising edge after reset=1.

Configuration
REQ-030 Macro SR_REG_BANK_CNT_EN defined: conflict_cnt port and counter SHALL exist per REQ-024..026.
REQ-031 Macro undefined: conflict_cnt port and counter logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-032 Package sr_pkg SHALL hold typedef enum sr_mode_t {SR_HOLD, SR_SET_DOM, SR_RST_DOM, SR_TOGGLE} and constant SR_MAX_WIDTH=32.
REQ-033 One sub-module sr_cell (single channel: q register, next-state per MODE, conflict and sticky flag) SHALL be instantiated WIDTH times via generate; counter lives in sr_reg_bank.

Verification (WIDTH=4, CNT_W=2, RST_VAL=4'b0101)
REQ-034 Hold reset=0 mid-cycle -> q=4'b0101, qbar=4'b1010 immediately, before next clk edge.
REQ-035 en=1, s=4'b0011, r=4'b1100 -> after one edge q=4'b0011, conflict=0; then s=r=0 -> q holds 4'b0011.
REQ-036 MODE=SR_TOGGLE, q=4'b0011, s=r=4'b1111 for two edges -> q=4'b1100 then 4'b0011; conflict=4'b1111 each cycle, err_sticky=4'b1111.
REQ-037 en=0, s=r=4'b1111 -> q unchanged, conflict=0, err_sticky unchanged, conflict_cnt unchanged.
REQ-038 CNT_EN build: 5 consecutive conflict edges -> conflict_cnt 1,2,3,3,3; then err_clr=1 with s[0]=r[0]=1 -> conflict_cnt=1, err_sticky[0]=1, other bits 0.
REQ-039 MODE=SR_SET_DOM and SR_RST_DOM with s=r=4'b0001 from q=4'b0000/4'b0001 -> q[0]=1 and q[0]=0 respectively.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared types and limits for the SR register bank.
package sr_pkg;

    // Behaviour of a channel when set and reset are requested together
    typedef enum logic [1:0] {
        SR_HOLD,
        SR_SET_DOM,
        SR_RST_DOM,
        SR_TOGGLE
    } sr_mode_t;

    localparam int SR_MAX_WIDTH = 32;

endpackage

// File: rtl/sr_cell.sv
// One SR channel: state register, conflict pulse and sticky conflict flag.
module sr_cell
    import sr_pkg::*;
#(
    parameter sr_mode_t MODE    = SR_HOLD,
    parameter logic     RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic s,
    input  logic r,
    input  logic err_clr,
    output logic q,
    output logic conflict,
    output logic err_sticky
);

    logic q_q, q_d;
    logic conf_q, conf_d;
    logic sticky_q, sticky_d;

    always_comb begin
        q_d      = q_q;
        conf_d   = 1'b0;
        sticky_d = sticky_q;
        if (en) begin
            case ({s, r})
                2'b10: q_d = 1'b1;
                2'b01: q_d = 1'b0;
                2'b11: begin
                    conf_d = 1'b1;
                    case (MODE)
                        SR_SET_DOM: q_d = 1'b1;
                        SR_RST_DOM: q_d = 1'b0;
                        SR_TOGGLE:  q_d = ~q_q;
                        default:    q_d = q_q;
                    endcase
                end
                default: q_d = q_q;
            endcase
        end
        // A fresh conflict outranks a simultaneous clear
        if (err_clr) sticky_d = 1'b0;
        if (conf_d)  sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q      <= RST_VAL;
            conf_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            conf_q   <= conf_d;
            sticky_q <= sticky_d;
        end
    end

    assign q          = q_q;
    assign conflict   = conf_q;
    assign err_sticky = sticky_q;

endmodule

// File: rtl/sr_reg_bank.sv
// Bank of WIDTH independent SR channels with conflict reporting.
// Define SR_REG_BANK_CNT_EN to add the saturating conflict_cnt output.
module sr_reg_bank
    import sr_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter sr_mode_t        MODE    = SR_HOLD,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] conflict,
    output logic [WIDTH-1:0] err_sticky
`ifdef SR_REG_BANK_CNT_EN
   ,output logic [CNT_W-1:0] conflict_cnt
`endif
);

    if (WIDTH < 1 || WIDTH > SR_MAX_WIDTH) begin : g_bad_width
        $error("sr_reg_bank: WIDTH out of range");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .MODE    (MODE),
            .RST_VAL (RST_VAL[i])
        ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .en         (en),
            .s          (s[i]),
            .r          (r[i]),
            .err_clr    (err_clr),
            .q          (q[i]),
            .conflict   (conflict[i]),
            .err_sticky (err_sticky[i])
        );
    end

    assign qbar = ~q;

`ifdef SR_REG_BANK_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             any_conf;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts conflict edges, not conflicting channels
    assign any_conf = en & (|(s & r));

    always_comb begin
        cnt_d = cnt_q;
        if (err_clr) begin
            cnt_d = any_conf ? CNT_ONE : '0;
        end else if (any_conf && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sr_reg_bank.sv
// Scoreboard bench for sr_reg_bank: one instance per MODE, shared stimulus.
module tb_sr_reg_bank;
    import sr_pkg::*;

    localparam int         W  = 4;
    localparam int         CW = 2;
    localparam logic [3:0] RV = 4'b0101;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       err_clr = 1'b0;
    logic [3:0] s = '0;
    logic [3:0] r = '0;

    logic [3:0] q_w  [4];
    logic [3:0] qb_w [4];
    logic [3:0] cf_w [4];
    logic [3:0] st_w [4];
`ifdef SR_REG_BANK_CNT_EN
    logic [CW-1:0] cnt_w [4];
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0][3:0] q;
        logic [3:0]      conf;
        logic [3:0]      st;
        int              cnt;
    } exp_t;

    exp_t sbq[$];

    logic [3:0] mq [4];
    logic [3:0] mst;
    int         mcnt;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sr_reg_bank #(
            .WIDTH   (W),
            .MODE    (sr_mode_t'(g)),
            .RST_VAL (RV),
            .CNT_W   (CW)
        ) dut (
            .clk          (clk),
            .reset        (reset),
            .en           (en),
            .s            (s),
            .r            (r),
            .err_clr      (err_clr),
            .q            (q_w[g]),
            .qbar         (qb_w[g]),
            .conflict     (cf_w[g]),
            .err_sticky   (st_w[g])
`ifdef SR_REG_BANK_CNT_EN
           ,.conflict_cnt (cnt_w[g])
`endif
        );
    end

    task automatic chk(input string nm, input int m, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s mode%0d actual=%b required=%b t=%0t", nm, m, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 4; m++) mq[m] = RV;
        mst  = '0;
        mcnt = 0;
    endtask

    // Behavioural reference: apply the SR truth table per mode, then push the result
    task automatic step(input logic [3:0] si, input logic [3:0] ri, input logic e, input logic c);
        logic [3:0] conf;
        exp_t x;
        @(negedge clk);
        s = si; r = ri; en = e; err_clr = c;
        conf = e ? (si & ri) : 4'b0000;
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 4; i++) begin
                if (e) begin
                    if (si[i] && !ri[i])      mq[m][i] = 1'b1;
                    else if (!si[i] && ri[i]) mq[m][i] = 1'b0;
                    else if (si[i] && ri[i]) begin
                        if (m == 1)      mq[m][i] = 1'b1;
                        else if (m == 2) mq[m][i] = 1'b0;
                        else if (m == 3) mq[m][i] = ~mq[m][i];
                    end
                end
            end
        end
        mst = c ? conf : (mst | conf);
        if (c)              mcnt = (conf != 0) ? 1 : 0;
        else if (conf != 0) mcnt = (mcnt >= 3) ? 3 : mcnt + 1;
        for (int m = 0; m < 4; m++) x.q[m] = mq[m];
        x.conf = conf;
        x.st   = mst;
        x.cnt  = mcnt;
        sbq.push_back(x);
    endtask

    task automatic chk_reset_state(input string tag);
        for (int m = 0; m < 4; m++) begin
            chk({tag, "_q"},    m, q_w[m],  RV);
            chk({tag, "_qbar"}, m, qb_w[m], ~RV);
            chk({tag, "_conf"}, m, cf_w[m], 4'b0000);
            chk({tag, "_st"},   m, st_w[m], 4'b0000);
`ifdef SR_REG_BANK_CNT_EN
            chk({tag, "_cnt"},  m, 4'(cnt_w[m]), 4'b0000);
`endif
        end
    endtask

    // Assert reset mid-cycle with a conflicting update pending
    task automatic mid_reset();
        @(negedge clk);
        s = 4'hF; r = 4'hF; en = 1'b1; err_clr = 1'b0;
        #2 reset = 1'b0;
        #1 chk_reset_state("rst_async");
        @(posedge clk);
        #1 chk_reset_state("rst_held");
        @(negedge clk);
        s = '0; r = '0; en = 1'b0;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                for (int m = 0; m < 4; m++) begin
                    chk("q",    m, q_w[m],  x.q[m]);
                    chk("qbar", m, qb_w[m], ~x.q[m]);
                    chk("conf", m, cf_w[m], x.conf);
                    chk("st",   m, st_w[m], x.st);
`ifdef SR_REG_BANK_CNT_EN
                    chk("cnt",  m, 4'(cnt_w[m]), 4'(x.cnt));
`endif
                end
            end
        end
    end

    initial begin : driver
        model_reset();
        #2 reset = 1'b0;
        #1 chk_reset_state("rst_init");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        step(4'b0011, 4'b1100, 1'b1, 1'b0);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        step(4'b1111, 4'b1111, 1'b0, 1'b0);
        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        step(4'b0001, 4'b0001, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b0000, 4'b0001, 1'b1, 1'b0);
        step(4'b0001, 4'b0001, 1'b1, 1'b0);
        step(4'b0001, 4'b0000, 1'b1, 1'b0);
        step(4'b0001, 4'b0001, 1'b1, 1'b0);

        mid_reset();
        step(4'b1000, 4'b0000, 1'b1, 1'b0);

        for (int n = 0; n < 300; n++) begin
            step(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0));
        end

        mid_reset();
        for (int n = 0; n < 40; n++) begin
            step(4'($urandom), 4'($urandom), 1'b1, ($urandom_range(0, 5) == 0));
        end

        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain actual=%0d required=0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
